// File: rtl/memory_arbiter.sv
// Arbiter sharing one single-ported RAM between instruction fetch and data access.
// Data has priority over fetch, bounded by a streak limit so a pending fetch cannot starve.
module memory_arbiter #(
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              merr
);

  localparam int unsigned DW = $clog2(MAX_D_STREAK + 1);
  localparam logic [DW-1:0]     STREAK_MAX = DW'(MAX_D_STREAK);
  localparam logic [WORD_W-1:0] ERR_WORD   = WORD_W'(32'hBAD1_BAD1);

  typedef enum logic [1:0] {IDLE, IFETCH, DACCESS} state_e;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dstreak_q, dstreak_d;
  logic          conflict_q, conflict_d;

  ramstate_e rs;
  logic      dreq, done, err;

  assign rs   = ramstate_e'(ramstate);
  assign dreq = dREN | dWEN;
  assign done = (rs == RAM_ACCESS) || (rs == RAM_ERROR);
  assign err  = (rs == RAM_ERROR);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      dstreak_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dstreak_q  <= dstreak_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dstreak_d  = dstreak_q;
    conflict_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dreq && !(iREN && (dstreak_q == STREAK_MAX))) begin
          state_d    = DACCESS;
          conflict_d = dREN & dWEN;
          if (dstreak_q != STREAK_MAX) dstreak_d = dstreak_q + DW'(1);
        end else if (iREN) begin
          state_d   = IFETCH;
          dstreak_d = '0;
        end
      end
      // A dropped request aborts the access; the streak is left as it was.
      IFETCH:  if (!iREN || done) state_d = IDLE;
      DACCESS: if (!dreq || done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    merr     = 1'b0;
    unique case (state_q)
      IFETCH: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (done) begin
            iload = err ? ERR_WORD : ramload;
            merr  = err;
          end
        end
      end
      DACCESS: begin
        if (dreq) begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (done && !dWEN) dload = err ? ERR_WORD : ramload;
          // Conflict flag is registered at grant so it pulses in the first access cycle.
          merr = (done && err) || conflict_q;
        end
      end
      default: ;
    endcase
  end

  assign iwait = iREN & ~((state_q == IFETCH) & done);
  assign dwait = dreq & ~((state_q == DACCESS) & done);

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios then random traffic, all checked
// cycle by cycle against a transaction-level model of who owns the RAM.
module tb_memory_arbiter;

  localparam int MAX = 4;
  localparam logic [31:0] BAD = 32'hBAD1_BAD1;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, merr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  memory_arbiter #(.WORD_W(32), .MAX_D_STREAK(MAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: owner 0 = nobody, 1 = instruction fetch, 2 = data access.
  int owner = 0;
  int streak = 0;
  bit cpend = 0;

  bit rec_en = 0;
  int seq[$];
  int ilow = 0;
  bit last_iw, last_dw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit dq, dn, er, ci, cd;
    int n_owner, n_streak;
    bit n_cpend;
    logic [31:0] e_addr, e_store, e_il, e_dl;
    #1;
    if (!nRST) begin owner = 0; streak = 0; cpend = 0; end
    dq = dREN | dWEN;
    dn = ramstate >= 2'd2;
    er = ramstate == 2'd3;
    ci = (owner == 1) && iREN && dn;
    cd = (owner == 2) && dq && dn;
    e_addr  = (owner == 1 && iREN) ? iaddr : (owner == 2 && dq) ? daddr : 32'h0;
    e_store = (owner == 2 && dWEN) ? dstore : 32'h0;
    e_il = ci ? (er ? BAD : ramload) : 32'h0;
    e_dl = (cd && !dWEN) ? (er ? BAD : ramload) : 32'h0;
    chk("ramREN", ramREN, ((owner == 1 && iREN) || (owner == 2 && dREN && !dWEN)));
    chk("ramWEN", ramWEN, (owner == 2 && dWEN));
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("iwait", iwait, (iREN && !(owner == 1 && dn)));
    chk("dwait", dwait, (dq && !(owner == 2 && dn)));
    chk("iload", iload, e_il);
    chk("dload", dload, e_dl);
    chk("merr", merr, (((ci || cd) && er) || (owner == 2 && cpend && dq)));
    chk("dstreak", 32'(dut.dstreak_q), streak);
    if (iREN && !iwait) ilow++;
    if (rec_en && dq && !dwait) seq.push_back(0);
    if (rec_en && iREN && !iwait) seq.push_back(1);
    last_iw = iwait;
    last_dw = dwait;
    n_owner = owner; n_streak = streak; n_cpend = 0;
    if (owner == 0) begin
      if (dq && !(iREN && streak == MAX)) begin
        n_owner = 2;
        n_streak = (streak < MAX) ? streak + 1 : MAX;
        n_cpend = dREN && dWEN;
      end else if (iREN) begin
        n_owner = 1;
        n_streak = 0;
      end
    end else if (owner == 1) begin
      if (!iREN || dn) n_owner = 0;
    end else begin
      if (!dq || dn) n_owner = 0;
    end
    @(posedge CLK);
    if (nRST) begin owner = n_owner; streak = n_streak; cpend = n_cpend; end
    @(negedge CLK);
  endtask

  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                      input logic [31:0] da, input logic [31:0] ds,
                      input logic [1:0] rs, input logic [31:0] rl);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
    cycle();
  endtask

  initial begin
    nRST = 1'b0;
    // Reset with a fetch already pending: waits follow the request, RAM side quiet.
    step(1, 32'h40, 0, 0, 0, 0, 2'd0, 0);
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);
    nRST = 1'b1;
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Lone fetch.
    ilow = 0;
    step(1, 32'h40, 0, 0, 0, 0, 2'd0, 0);
    step(1, 32'h40, 0, 0, 0, 0, 2'd1, 0);
    step(1, 32'h40, 0, 0, 0, 0, 2'd2, 32'h2002_0004);
    chk("fetch_ilow_cycles", ilow, 1);
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Simultaneous fetch and data read: data first, bubble, then fetch.
    step(1, 32'h44, 1, 0, 32'h100, 0, 2'd0, 0);
    step(1, 32'h44, 1, 0, 32'h100, 0, 2'd2, 32'h1111_2222);
    step(1, 32'h44, 0, 0, 0, 0, 2'd0, 0);
    step(1, 32'h44, 0, 0, 0, 0, 2'd2, 32'h3333_4444);
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Abort: fetch dropped while RAM busy.
    step(1, 32'h48, 0, 0, 0, 0, 2'd0, 0);
    step(1, 32'h48, 0, 0, 0, 0, 2'd1, 0);
    step(0, 32'h48, 0, 0, 0, 0, 2'd1, 0);
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Read/write conflict, then an erroring read.
    step(0, 0, 1, 1, 32'h200, 32'hDEAD, 2'd0, 0);
    step(0, 0, 1, 1, 32'h200, 32'hDEAD, 2'd2, 32'h5555_5555);
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);
    step(0, 0, 1, 0, 32'h204, 0, 2'd0, 0);
    step(0, 0, 1, 0, 32'h204, 0, 2'd3, 32'h7777_7777);
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Reset in the middle of a write; fetch pending across release.
    step(1, 32'h50, 0, 1, 32'h300, 32'h1234, 2'd0, 0);
    step(1, 32'h50, 0, 1, 32'h300, 32'h1234, 2'd1, 0);
    nRST = 1'b0;
    step(1, 32'h50, 0, 1, 32'h300, 32'h1234, 2'd1, 0);
    nRST = 1'b1;
    step(1, 32'h50, 0, 0, 0, 0, 2'd0, 0);
    step(1, 32'h50, 0, 0, 0, 0, 2'd2, 32'hABCD_0001);
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Starvation bound from a clean streak.
    nRST = 1'b0;
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);
    nRST = 1'b1;
    seq.delete();
    rec_en = 1;
    for (int i = 0; i < 26; i++) step(1, 32'h60, 1, 0, 32'h400 + i, 0, 2'd2, $urandom);
    rec_en = 0;
    chk("starve_count", (seq.size() >= 10), 1);
    for (int i = 0; i < 10; i++) begin
      if (i < seq.size()) chk("starve_order", seq[i], ((i % 5) == 4));
    end
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Random traffic; requesters mostly hold until served, sometimes abort.
    for (int i = 0; i < 400; i++) begin
      bit ir, dr, dw;
      ir = (iREN && last_iw) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
      if ((dREN || dWEN) && last_dw) begin
        dr = dREN; dw = dWEN;
        if ($urandom_range(0, 9) == 0) begin dr = 0; dw = 0; end
      end else begin
        dr = ($urandom_range(0, 2) == 0);
        dw = ($urandom_range(0, 3) == 0);
      end
      step(ir, $urandom, dr, dw, $urandom, $urandom,
           2'($urandom_range(0, 3)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
